// File: rtl/alu_request_arbiter.sv
// alu_request_arbiter: round-robin sharing of one registered ALU path between two requesters,
// one operation in flight, result returned over a per-requester valid/ready handshake.
module alu_request_arbiter #(
    parameter int N   = 4,
    parameter int LAT = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_req0_valid,
    input  logic [N-1:0] i_req0_a,
    input  logic [N-1:0] i_req0_b,
    input  logic [3:0]   i_req0_sel,
    output logic         o_req0_ready,
    input  logic         i_req1_valid,
    input  logic [N-1:0] i_req1_a,
    input  logic [N-1:0] i_req1_b,
    input  logic [3:0]   i_req1_sel,
    output logic         o_req1_ready,
    output logic [N-1:0] o_alu_a,
    output logic [N-1:0] o_alu_b,
    output logic [3:0]   o_alu_sel,
    input  logic [N-1:0] i_alu_result,
    input  logic [3:0]   i_alu_flags,
    output logic         o_resp0_valid,
    output logic         o_resp1_valid,
    input  logic         i_resp0_ready,
    input  logic         i_resp1_ready,
    output logic [N-1:0] o_resp_result,
    output logic [3:0]   o_resp_flags,
    output logic         o_busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_last;
    logic       w_gnt;
    logic       w_acc;
    logic       w_resp_hs;
    // r_last holds the previous winner; it resets to 1 so requester 0 takes the first tie
    assign w_gnt        = (i_req0_valid & i_req1_valid) ? ~r_last : i_req1_valid;
    assign w_acc        = (r_state == IDLE) & (i_req0_valid | i_req1_valid) & i_rst_n;
    assign o_req0_ready = w_acc & ~w_gnt;
    assign o_req1_ready = w_acc & w_gnt;
    assign w_resp_hs    = r_last ? (o_resp1_valid & i_resp1_ready) : (o_resp0_valid & i_resp0_ready);
    assign o_busy       = r_state != IDLE;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_last        <= 1'b1;
            o_alu_a       <= '0;
            o_alu_b       <= '0;
            o_alu_sel     <= '0;
            o_resp0_valid <= 1'b0;
            o_resp1_valid <= 1'b0;
            o_resp_result <= '0;
            o_resp_flags  <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_acc) begin
                    o_alu_a   <= w_gnt ? i_req1_a : i_req0_a;
                    o_alu_b   <= w_gnt ? i_req1_b : i_req0_b;
                    o_alu_sel <= w_gnt ? i_req1_sel : i_req0_sel;
                    r_cnt     <= '0;
                    r_last    <= w_gnt;
                    r_state   <= EXEC;
                end
                EXEC: if (r_cnt == 4'(LAT)) begin
                    o_resp_result <= i_alu_result;
                    o_resp_flags  <= i_alu_flags;
                    o_resp0_valid <= ~r_last;
                    o_resp1_valid <= r_last;
                    r_state       <= RESP;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
                RESP: if (w_resp_hs) begin
                    o_resp0_valid <= 1'b0;
                    o_resp1_valid <= 1'b0;
                    r_state       <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_request_arbiter.sv
// tb_alu_request_arbiter: directed bench; LAT=2 instance driven by a pipelined ALU stub,
// LAT=4 instance with a hand-driven ALU output to pin the capture edge.
module tb_alu_request_arbiter;
    localparam int N = 4;
    localparam int L = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   vec = 0;
    int   err = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic v0 = 0, v1 = 0, rr0 = 0, rr1 = 0;
    logic [N-1:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
    logic [3:0] s0 = 0, s1 = 0;
    logic rdy0, rdy1, rv0, rv1, busy;
    logic [N-1:0] alu_a, alu_b, alu_res, res;
    logic [3:0] alu_sel, alu_flg, flg;

    alu_request_arbiter #(.N(N), .LAT(L)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0_valid(v0), .i_req0_a(a0), .i_req0_b(b0), .i_req0_sel(s0), .o_req0_ready(rdy0),
        .i_req1_valid(v1), .i_req1_a(a1), .i_req1_b(b1), .i_req1_sel(s1), .o_req1_ready(rdy1),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_sel(alu_sel),
        .i_alu_result(alu_res), .i_alu_flags(alu_flg),
        .o_resp0_valid(rv0), .o_resp1_valid(rv1), .i_resp0_ready(rr0), .i_resp1_ready(rr1),
        .o_resp_result(res), .o_resp_flags(flg), .o_busy(busy)
    );

    // stub ALU: flags = {2'b00, zero, carry}
    function automatic logic [N+3:0] alu_f(input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] s);
        logic [N:0] r;
        r = s == 4'd0 ? {1'b0, a} + {1'b0, b} : s == 4'd1 ? {1'b0, a} - {1'b0, b} :
            s == 4'd2 ? {1'b0, a & b} : s == 4'd3 ? {1'b0, a | b} : {1'b0, a ^ b};
        return {r[N-1:0], 2'b00, r[N-1:0] == '0, r[N]};
    endfunction

    logic [N+3:0] st [L];
    always @(posedge clk) begin
        st[0] <= alu_f(alu_a, alu_b, alu_sel);
        for (int i = 1; i < L; i++) st[i] <= st[i-1];
    end
    assign alu_res = st[L-1][N+3:4];
    assign alu_flg = st[L-1][3:0];

    logic w0 = 0, x_rr0 = 0;
    logic [N-1:0] wa = 0, wb = 0, x_in = 0;
    logic [3:0] ws = 0, x_fin = 0;
    logic w_rdy0, w_rdy1, x_rv0, x_rv1, x_busy;
    logic [N-1:0] x_a, x_b, x_res;
    logic [3:0] x_sel, x_flg;
    logic z1 = 0, zr1 = 0;
    logic [N-1:0] za = 0;
    logic [3:0] zs = 0;

    alu_request_arbiter #(.N(N), .LAT(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0_valid(w0), .i_req0_a(wa), .i_req0_b(wb), .i_req0_sel(ws), .o_req0_ready(w_rdy0),
        .i_req1_valid(z1), .i_req1_a(za), .i_req1_b(za), .i_req1_sel(zs), .o_req1_ready(w_rdy1),
        .o_alu_a(x_a), .o_alu_b(x_b), .o_alu_sel(x_sel),
        .i_alu_result(x_in), .i_alu_flags(x_fin),
        .o_resp0_valid(x_rv0), .o_resp1_valid(x_rv1), .i_resp0_ready(x_rr0), .i_resp1_ready(zr1),
        .o_resp_result(x_res), .o_resp_flags(x_flg), .o_busy(x_busy)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        vec++;
        if ({rdy0, rdy1, rv0, rv1, busy} !== 5'b0) begin
            err++;
            $display("FAIL reset_ctrl: got %b expected 00000", {rdy0, rdy1, rv0, rv1, busy});
        end
        vec++;
        if ({alu_a, alu_b, alu_sel, res, flg} !== 20'h0) begin
            err++;
            $display("FAIL reset_data: got %h expected 00000", {alu_a, alu_b, alu_sel, res, flg});
        end
        vec++;
        if ({w_rdy0, w_rdy1, x_rv0, x_rv1, x_busy, x_a, x_res} !== 13'h0) begin
            err++;
            $display("FAIL reset_lat4: got %h expected 0", {w_rdy0, w_rdy1, x_rv0, x_rv1, x_busy, x_a, x_res});
        end
        step;
        step;
        rst_n = 1'b1;
        step;
    endtask

    task automatic test_single;
        v0 = 1; a0 = 4'h3; b0 = 4'h5; s0 = 4'h0;
        #1;
        vec++;
        if ({rdy0, rdy1} !== 2'b10) begin
            err++;
            $display("FAIL single_ready: got %b expected 10", {rdy0, rdy1});
        end
        step;
        v0 = 0; a0 = 4'hE;
        vec++;
        if ({alu_a, alu_b, alu_sel, busy} !== {4'h3, 4'h5, 4'h0, 1'b1}) begin
            err++;
            $display("FAIL single_alu_in: got %h expected %h", {alu_a, alu_b, alu_sel, busy}, {4'h3, 4'h5, 4'h0, 1'b1});
        end
        step;
        step;
        vec++;
        if ({rv0, rv1} !== 2'b00) begin
            err++;
            $display("FAIL single_early: got %b expected 00", {rv0, rv1});
        end
        step;
        vec++;
        if ({rv0, rv1, res, flg} !== {2'b10, 4'h8, 4'h0}) begin
            err++;
            $display("FAIL single_resp: got %h expected %h", {rv0, rv1, res, flg}, {2'b10, 4'h8, 4'h0});
        end
        rr0 = 1;
        step;
        rr0 = 0;
        vec++;
        if ({rv0, busy} !== 2'b00) begin
            err++;
            $display("FAIL single_done: got %b expected 00", {rv0, busy});
        end
    endtask

    task automatic test_simultaneous;
        int n_acc = 0, n_rsp = 0, last = 0, idle = 0;
        logic [9:0] exp;
        rst_n = 0;
        step;
        rst_n = 1;
        step;
        a0 = 4'h1; b0 = 4'h2; s0 = 4'h0;
        a1 = 4'hC; b1 = 4'h6; s1 = 4'h0;
        v0 = 1; v1 = 1; rr0 = 1; rr1 = 1;
        #1;
        for (int i = 0; i < 40 && n_rsp < 4; i++) begin
            if (rdy0 | rdy1) begin
                vec++;
                if (rdy1 !== n_acc[0]) begin
                    err++;
                    $display("FAIL simul_order: op %0d got req%0d expected req%0d", n_acc, rdy1, n_acc[0]);
                end
                if (n_acc > 0) begin
                    vec++;
                    if (cyc - last !== 5) begin
                        err++;
                        $display("FAIL simul_spacing: got %0d expected 5", cyc - last);
                    end
                end
                last = cyc;
                n_acc++;
            end
            if (n_acc >= 1 && n_acc < 4 && !busy) idle++;
            if (rv0 | rv1) begin
                exp = n_rsp[0] ? {2'b01, 4'h2, 4'h1} : {2'b10, 4'h3, 4'h0};
                vec++;
                if ({rv0, rv1, res, flg} !== exp) begin
                    err++;
                    $display("FAIL simul_resp: rsp %0d got %h expected %h", n_rsp, {rv0, rv1, res, flg}, exp);
                end
                n_rsp++;
            end
            if (n_rsp < 4) step;
        end
        vec++;
        if (n_rsp !== 4) begin
            err++;
            $display("FAIL simul_count: got %0d expected 4", n_rsp);
        end
        vec++;
        if (idle !== 3) begin
            err++;
            $display("FAIL simul_idle: got %0d expected 3", idle);
        end
        v0 = 0; v1 = 0;
        step;
        rr0 = 0; rr1 = 0;
        step;
    endtask

    task automatic test_backpressure;
        v1 = 1; a1 = 4'h7; b1 = 4'h2; s1 = 4'h1;
        #1;
        vec++;
        if ({rdy0, rdy1} !== 2'b01) begin
            err++;
            $display("FAIL bp_accept: got %b expected 01", {rdy0, rdy1});
        end
        step;
        v1 = 0; v0 = 1; a0 = 4'h2; b0 = 4'h2; s0 = 4'h3; rr0 = 1;
        for (int i = 0; i < 10 && !rv1; i++) step;
        for (int i = 0; i < 10; i++) begin
            vec++;
            if ({rv1, res, rdy0} !== {1'b1, 4'h5, 1'b0}) begin
                err++;
                $display("FAIL bp_hold: cycle %0d got %h expected %h", i, {rv1, res, rdy0}, {1'b1, 4'h5, 1'b0});
            end
            step;
        end
        rr0 = 0; rr1 = 1;
        step;
        rr1 = 0;
        vec++;
        if ({rv1, rdy0} !== 2'b01) begin
            err++;
            $display("FAIL bp_release: got %b expected 01", {rv1, rdy0});
        end
        step;
        v0 = 0;
        for (int i = 0; i < 10 && !rv0; i++) step;
        vec++;
        if ({rv0, res, flg} !== {1'b1, 4'h2, 4'h0}) begin
            err++;
            $display("FAIL bp_next: got %h expected %h", {rv0, res, flg}, {1'b1, 4'h2, 4'h0});
        end
        rr0 = 1;
        step;
        rr0 = 0;
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        v0 = 1; a0 = 4'h9; b0 = 4'h9; s0 = 4'h0;
        step;
        v0 = 0;
        step;
        rst_n = 0;
        #1;
        vec++;
        if ({busy, rv0, rv1, rdy0, rdy1, alu_a, alu_b, alu_sel, res, flg} !== 25'h0) begin
            err++;
            $display("FAIL rmid_clear: got %h expected 0", {busy, rv0, rv1, rdy0, rdy1, alu_a, alu_b, alu_sel, res, flg});
        end
        step;
        step;
        rst_n = 1;
        for (int i = 0; i < 8; i++) begin
            step;
            if (rv0) seen = 1;
        end
        vec++;
        if (seen !== 0) begin
            err++;
            $display("FAIL rmid_ghost: got resp0_valid=1 expected 0");
        end
        v1 = 1; a1 = 4'hF; b1 = 4'h1; s1 = 4'h0;
        #1;
        vec++;
        if (rdy1 !== 1'b1) begin
            err++;
            $display("FAIL rmid_accept: got %b expected 1", rdy1);
        end
        step;
        v1 = 0;
        step;
        step;
        step;
        vec++;
        if ({rv1, res, flg} !== {1'b1, 4'h0, 4'h3}) begin
            err++;
            $display("FAIL rmid_resp: got %h expected %h", {rv1, res, flg}, {1'b1, 4'h0, 4'h3});
        end
        rr1 = 1;
        step;
        rr1 = 0;
    endtask

    task automatic test_back_to_back;
        logic [11:0] ops [3];
        logic [3:0] exr [3];
        int prev = 0;
        ops = '{12'h110, 12'h631, 12'h533};
        exr = '{4'h2, 4'h3, 4'h7};
        rr1 = 1;
        for (int k = 0; k < 3; k++) begin
            {a1, b1, s1} = ops[k];
            v1 = 1;
            #1;
            for (int i = 0; i < 20 && !rdy1; i++) step;
            vec++;
            if ({rdy1, rdy0} !== 2'b10) begin
                err++;
                $display("FAIL b2b_accept: op %0d got %b expected 10", k, {rdy1, rdy0});
            end
            if (k > 0) begin
                vec++;
                if (cyc - prev !== 5) begin
                    err++;
                    $display("FAIL b2b_spacing: op %0d got %0d expected 5", k, cyc - prev);
                end
            end
            prev = cyc;
            step;
            if (k == 2) v1 = 0;
            for (int i = 0; i < 10 && !rv1; i++) step;
            vec++;
            if ({rv1, rv0, res, flg} !== {2'b10, exr[k], 4'h0}) begin
                err++;
                $display("FAIL b2b_resp: op %0d got %h expected %h", k, {rv1, rv0, res, flg}, {2'b10, exr[k], 4'h0});
            end
            step;
        end
        rr1 = 0;
    endtask

    task automatic test_lat4;
        w0 = 1; wa = 4'h2; wb = 4'h3; ws = 4'h0;
        #1;
        vec++;
        if (w_rdy0 !== 1'b1) begin
            err++;
            $display("FAIL lat4_accept: got %b expected 1", w_rdy0);
        end
        step;
        w0 = 0; x_in = 4'hA; x_fin = 4'hF;
        step;
        x_in = 4'hB;
        step;
        x_in = 4'hC;
        step;
        x_in = 4'h9;
        step;
        x_in = 4'h6; x_fin = 4'h5;
        vec++;
        if (x_rv0 !== 1'b0) begin
            err++;
            $display("FAIL lat4_early: got %b expected 0", x_rv0);
        end
        step;
        x_in = 4'hD; x_fin = 4'hE;
        vec++;
        if ({x_rv0, x_res, x_flg, x_a, x_b} !== {1'b1, 4'h6, 4'h5, 4'h2, 4'h3}) begin
            err++;
            $display("FAIL lat4_capture: got %h expected %h", {x_rv0, x_res, x_flg, x_a, x_b}, {1'b1, 4'h6, 4'h5, 4'h2, 4'h3});
        end
        x_rr0 = 1;
        step;
        x_rr0 = 0;
        vec++;
        if ({x_rv0, x_busy, x_res} !== {2'b00, 4'h6}) begin
            err++;
            $display("FAIL lat4_done: got %h expected %h", {x_rv0, x_busy, x_res}, {2'b00, 4'h6});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_single;
        test_simultaneous;
        test_backpressure;
        test_reset_mid;
        test_back_to_back;
        test_lat4;
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
